// File: rtl/eig_ratio_converge.sv
// rtl/eig_ratio_converge.sv - converts divider ratio estimates to Q8.8 and emits the dominant eigenvalue once the estimates settle or time out
module eig_ratio_converge #(
    parameter logic [15:0] TOL        = 16'd4,
    parameter int          STABLE_CNT = 4,
    parameter int          MAX_ITER   = 64
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    input  logic [31:0] s_axis_dout_tdata,
    input  logic        s_axis_dout_tvalid,
    output logic [15:0] m_axis_eig_tdata,
    output logic        m_axis_eig_tvalid,
    input  logic        m_axis_eig_tready,
    output logic        converged,
    output logic        timeout,
    output logic        busy,
    output logic [7:0]  iter_count
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

    localparam logic [7:0] STABLE_LIMIT = 8'(STABLE_CNT);
    localparam logic [7:0] ITER_LIMIT   = 8'(MAX_ITER);

    logic [1:0]  state_q, state_d;
    logic [7:0]  iter_q, iter_d;
    logic [7:0]  stable_q, stable_d;
    logic [15:0] prev_q, prev_d;
    logic        prev_valid_q, prev_valid_d;
    logic        conv_q, conv_d;
    logic        tout_q, tout_d;
    logic [15:0] eig_q, eig_d;
    logic        mvalid_q, mvalid_d;

    logic signed [15:0] quot;
    logic [15:0]        cur;
    logic signed [16:0] diff;
    logic [16:0]        diff_abs;
    logic               sample_stable;
    logic [7:0]         stable_nxt;
    logic [7:0]         iter_nxt;
    logic               unused_frac_lsbs;

    // Low fraction byte is truncated away by the Q8.8 conversion.
    assign unused_frac_lsbs = ^s_axis_dout_tdata[7:0];

    always_comb begin
        quot = signed'(s_axis_dout_tdata[31:16]);
        if (quot > 16'sd127) begin
            cur = 16'h7FFF;
        end else if (quot < -16'sd128) begin
            cur = 16'h8000;
        end else begin
            cur = {s_axis_dout_tdata[23:16], s_axis_dout_tdata[15:8]};
        end
    end

    always_comb begin
        diff          = signed'({cur[15], cur}) - signed'({prev_q[15], prev_q});
        diff_abs      = diff[16] ? 17'(-diff) : 17'(diff);
        sample_stable = prev_valid_q && (diff_abs <= {1'b0, TOL});
        stable_nxt    = sample_stable ? stable_q + 8'd1 : 8'd0;
        iter_nxt      = iter_q + 8'd1;
    end

    always_comb begin
        state_d      = state_q;
        iter_d       = iter_q;
        stable_d     = stable_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        conv_d       = conv_q;
        tout_d       = tout_q;
        eig_d        = eig_q;
        mvalid_d     = mvalid_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d      = ST_TRACK;
                    iter_d       = 8'd0;
                    stable_d     = 8'd0;
                    prev_valid_d = 1'b0;
                    conv_d       = 1'b0;
                    tout_d       = 1'b0;
                end
            end
            ST_TRACK: begin
                if (s_axis_dout_tvalid) begin
                    iter_d       = iter_nxt;
                    stable_d     = stable_nxt;
                    prev_d       = cur;
                    prev_valid_d = 1'b1;
                    // Convergence takes priority when both limits land on the same sample.
                    if (stable_nxt == STABLE_LIMIT) begin
                        state_d  = ST_OUT;
                        conv_d   = 1'b1;
                        eig_d    = cur;
                        mvalid_d = 1'b1;
                    end else if (iter_nxt == ITER_LIMIT) begin
                        state_d  = ST_OUT;
                        tout_d   = 1'b1;
                        eig_d    = cur;
                        mvalid_d = 1'b1;
                    end
                end
            end
            ST_OUT: begin
                if (m_axis_eig_tready) begin
                    state_d  = ST_IDLE;
                    mvalid_d = 1'b0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                mvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            iter_q       <= 8'd0;
            stable_q     <= 8'd0;
            prev_q       <= 16'd0;
            prev_valid_q <= 1'b0;
            conv_q       <= 1'b0;
            tout_q       <= 1'b0;
            eig_q        <= 16'd0;
            mvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            iter_q       <= iter_d;
            stable_q     <= stable_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            conv_q       <= conv_d;
            tout_q       <= tout_d;
            eig_q        <= eig_d;
            mvalid_q     <= mvalid_d;
        end
    end

    assign m_axis_eig_tdata  = eig_q;
    assign m_axis_eig_tvalid = mvalid_q;
    assign converged         = conv_q;
    assign timeout           = tout_q;
    assign busy              = (state_q == ST_TRACK) || (state_q == ST_OUT);
    assign iter_count        = iter_q;

endmodule

// File: tb/tb_eig_ratio_converge.sv
// tb/tb_eig_ratio_converge.sv - scoreboard bench for eig_ratio_converge
module tb_eig_ratio_converge;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] s_tdata = 32'd0;
    logic        s_tvalid = 1'b0;
    logic [15:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready = 1'b1;
    logic        converged;
    logic        timeout;
    logic        busy;
    logic [7:0]  iter_count;

    eig_ratio_converge dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .start              (start),
        .s_axis_dout_tdata  (s_tdata),
        .s_axis_dout_tvalid (s_tvalid),
        .m_axis_eig_tdata   (m_tdata),
        .m_axis_eig_tvalid  (m_tvalid),
        .m_axis_eig_tready  (m_tready),
        .converged          (converged),
        .timeout            (timeout),
        .busy               (busy),
        .iter_count         (iter_count)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [15:0] d;
        logic        c;
        logic        t;
        logic [7:0]  n;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic logic [31:0] q88(input logic [15:0] v);
        return {{8{v[15]}}, v, 8'h00};
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] d);
        s_tdata  = d;
        s_tvalid = 1'b1;
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) tick();
        tests++;
        if (exp_q.size() > 0) begin
            fails++;
            $display("FAIL %s: output not seen, %0d pending, expected 0", name, exp_q.size());
            exp_q.delete();
        end
        tick();
    endtask

    // Monitor: pops and compares on every accepted output beat.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got tdata %h, expected no output", m_tdata);
                end else begin
                    e = exp_q.pop_front();
                    check("out_tdata", 32'(m_tdata), 32'(e.d));
                    check("out_converged", 32'(converged), 32'(e.c));
                    check("out_timeout", 32'(timeout), 32'(e.t));
                    check("out_iter_count", 32'(iter_count), 32'(e.n));
                end
            end
        end
    end

    initial begin
        logic [15:0] conv_seq [5];
        logic [15:0] inst_seq [8];
        logic [31:0] sat_in   [3];
        logic [15:0] sat_out  [3];
        conv_seq = '{16'h0300, 16'h0302, 16'h0301, 16'h0303, 16'h0302};
        inst_seq = '{16'h0100, 16'h0101, 16'h0101, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200};
        sat_in   = '{32'h00C80000, 32'hFF000000, 32'hFFFE8000};
        sat_out  = '{16'h7FFF, 16'h8000, 16'hFE80};

        #12;
        check("rst_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_tdata", 32'(m_tdata), 32'd0);
        check("rst_flags", {30'd0, converged, timeout}, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_iter", 32'(iter_count), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();

        // tvalid in IDLE is ignored
        send(q88(16'h0100));
        check("idle_iter", 32'(iter_count), 32'd0);

        pulse_start();
        check("start_busy", 32'(busy), 32'd1);
        exp_q.push_back('{d: 16'h0302, c: 1'b1, t: 1'b0, n: 8'd5});
        for (int i = 0; i < 5; i++) send(q88(conv_seq[i]));
        drain("converge");
        check("conv_idle_busy", 32'(busy), 32'd0);
        check("conv_flag_hold", 32'(converged), 32'd1);

        pulse_start();
        check("restart_clears_conv", 32'(converged), 32'd0);
        exp_q.push_back('{d: 16'h0200, c: 1'b1, t: 1'b0, n: 8'd8});
        for (int i = 0; i < 8; i++) send(q88(inst_seq[i]));
        drain("instability");

        pulse_start();
        exp_q.push_back('{d: 16'h0180, c: 1'b0, t: 1'b1, n: 8'd64});
        for (int i = 0; i < 64; i++) send(q88(i[0] ? 16'h0180 : 16'h0100));
        drain("timeout");
        check("timeout_hold", 32'(timeout), 32'd1);

        for (int k = 0; k < 3; k++) begin
            pulse_start();
            exp_q.push_back('{d: sat_out[k], c: 1'b1, t: 1'b0, n: 8'd5});
            for (int i = 0; i < 5; i++) send(sat_in[k]);
            drain("saturation");
        end

        m_tready = 1'b0;
        pulse_start();
        exp_q.push_back('{d: 16'h0300, c: 1'b1, t: 1'b0, n: 8'd5});
        for (int i = 0; i < 5; i++) send(q88(16'h0300));
        for (int i = 0; i < 10; i++) begin
            s_tdata  = q88(16'h0500);
            s_tvalid = 1'b1;
            start    = 1'b1;
            tick();
            check("bp_tvalid", 32'(m_tvalid), 32'd1);
            check("bp_tdata", 32'(m_tdata), 32'h0300);
            check("bp_iter", 32'(iter_count), 32'd5);
            check("bp_conv", 32'(converged), 32'd1);
        end
        s_tvalid = 1'b0;
        start    = 1'b0;
        m_tready = 1'b1;
        drain("backpressure");
        check("bp_idle_busy", 32'(busy), 32'd0);
        check("bp_idle_tvalid", 32'(m_tvalid), 32'd0);
        check("bp_flag_hold", 32'(converged), 32'd1);
        check("bp_iter_hold", 32'(iter_count), 32'd5);

        pulse_start();
        send(q88(16'h0100));
        send(q88(16'h0100));
        check("pre_reset_iter", 32'(iter_count), 32'd2);
        #2;
        aresetn = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_iter", 32'(iter_count), 32'd0);
        check("arst_tvalid", 32'(m_tvalid), 32'd0);
        check("arst_flags", {30'd0, converged, timeout}, 32'd0);
        #3;
        aresetn = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) send(q88(16'h0100));
        check("post_rst_iter", 32'(iter_count), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);
        check("post_rst_tvalid", 32'(m_tvalid), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
